// File: rtl/uc_seq.sv
// Microcoded control unit: writable control store, multi-step sequencer with
// memory wait-state stalling, and an interrupt-entry state at instruction boundaries.
module uc_seq #(
  parameter int unsigned OPW   = 5,
  parameter int unsigned SW    = 2,
  parameter int unsigned NFLAG = 4,
  parameter int unsigned CSW   = 2
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [OPW-1:0]    opcode,
  input  logic [CSW-1:0]    cond_sel,
  input  logic [NFLAG-1:0]  flags,
  input  logic              irq,
  input  logic              mem_ready,
  input  logic              ucw_we,
  input  logic [OPW+SW-1:0] ucw_addr,
  input  logic [16:0]       ucw_data,
  output logic              ir_load,
  output logic              pc_inc,
  output logic              jmp,
  output logic              call,
  output logic              ret,
  output logic              wreg,
  output logic [1:0]        sreg_in,
  output logic              sb_alu,
  output logic              en_flag,
  output logic [2:0]        op_alu,
  output logic              wbus,
  output logic              irq_ack,
  output logic              ie,
  output logic [SW-1:0]     step_o
);

  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] EXEC  = 2'd1;
  localparam logic [1:0] INT   = 2'd2;

  localparam int unsigned   Depth   = 2 ** (OPW + SW);
  localparam logic [SW-1:0] StepMax = '1;

  logic [16:0]         store [Depth];
  logic [1:0]          state_q, state_d;
  logic [OPW-1:0]      ir_q, ir_d;
  logic [SW-1:0]       step_q, step_d;
  logic                ie_q, ie_d;
  logic                irq_pend_q, irq_pend_d;
  logic                irq_q;
  logic [16:0]         w;
  logic                advance;
  logic                flag_hit;
  logic                jmp_take;
  logic [2**CSW-1:0]   flags_ext;

  // Control store is deliberately not reset so contents survive RSTn.
  always_ff @(posedge CLK) begin
    if (ucw_we) store[ucw_addr] <= ucw_data;
  end

  assign w        = store[{ir_q, step_q}];
  assign advance  = ~w[14] | mem_ready;
  assign jmp_take = w[11] & flag_hit & advance;

  always_comb begin
    flags_ext              = '0;
    flags_ext[NFLAG-1:0]   = flags;
    flag_hit               = flags_ext[cond_sel];
  end

  always_comb begin
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    jmp     = 1'b0;
    call    = 1'b0;
    ret     = 1'b0;
    wreg    = 1'b0;
    sreg_in = 2'b00;
    sb_alu  = 1'b0;
    en_flag = 1'b0;
    op_alu  = 3'b000;
    wbus    = 1'b0;
    irq_ack = 1'b0;
    case (state_q)
      FETCH: ir_load = RSTn;
      EXEC: begin
        sreg_in = w[7:6];
        sb_alu  = w[5];
        op_alu  = w[3:1];
        wbus    = w[0] & advance;
        en_flag = w[4] & advance;
        wreg    = w[8] & advance;
        ret     = w[9] & advance;
        call    = w[10] & advance;
        jmp     = jmp_take;
        pc_inc  = w[12] & advance & ~jmp_take;
      end
      INT: begin
        call    = 1'b1;
        wbus    = 1'b1;
        irq_ack = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    step_d  = step_q;
    ie_d    = ie_q;
    case (state_q)
      FETCH: begin
        ir_d    = opcode;
        step_d  = '0;
        state_d = EXEC;
      end
      EXEC: begin
        if (advance) begin
          // Clear has priority over set when both bits are present.
          if (w[16])      ie_d = 1'b0;
          else if (w[15]) ie_d = 1'b1;
          // A saturated step counter ends the instruction even without last.
          if (w[13] || step_q == StepMax) begin
            step_d  = '0;
            state_d = (irq_pend_q && ie_d) ? INT : FETCH;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      INT: begin
        ie_d    = 1'b0;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    irq_pend_d = irq_pend_q;
    if (state_q == INT) irq_pend_d = 1'b0;
    if (irq && !irq_q)  irq_pend_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= FETCH;
      ir_q       <= '0;
      step_q     <= '0;
      ie_q       <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      step_q     <= step_d;
      ie_q       <= ie_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq;
    end
  end

  assign ie     = ie_q;
  assign step_o = step_q;

endmodule
